hazard_ctl: RTL and testbench
=============================

HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 clk  in  1  rising-edge clock; sole clock of the block.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 if_id_opcode  in  6  opcode of instruction in decode (IF/ID instr[31:26]).
REQ-004 if_id_rs  in  5  rs of decode instruction (instr[25:21]).
REQ-005 if_id_rt  in  5  rt of decode instruction (instr[20:16]).
REQ-006 id_ex_memread  in  1  memread bit of ID/EX M control (instruction in EX is a load).
REQ-007 id_ex_rt  in  5  ID/EX instrout_2016 (load destination).
REQ-008 ex_mem_branch_taken  in  1  branch in MEM resolved taken.
REQ-009 ext_stall  in  1  instruction-memory not ready; front end freeze request, may last many cycles.
REQ-010 pc_write  out  1  PC load enable.
REQ-011 if_id_write  out  1  IF/ID load enable.
REQ-012 ctl_bubble  out  1  force zero WB/M/EX control into ID/EX.
REQ-013 if_id_flush  out  1  clear IF/ID to all-zero (nop).
REQ-014 id_ex_flush  out  1  clear ID/EX.
REQ-015 state  out  2  registered FSM state: 00 RUN, 01 LDSTALL, 10 XSTALL, 11 FLUSH.
REQ-016 stall_timeout  out  1  sticky watchdog flag.
REQ-017 stall_count  out  16  load-use + ext stall cycles (statistics).
REQ-018 flush_count  out  16  taken-branch flush events (statistics).

Function
REQ-019 rt_src = 1 for opcode 000000 (R-type), 000100 (beq), 101011 (sw); else 0.
REQ-020 load_use = id_ex_memread & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (rt_src & id_ex_rt == if_id_rt)); combinational.
REQ-021 Control outputs combinational from current-cycle inputs; zero added latency; priority flush > ext_stall > load_use > run.
REQ-022 Flush (ex_mem_branch_taken=1): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, ctl_bubble=1; overrides ext_stall and load_use same cycle.
REQ-023 Ext stall (no flush, ext_stall=1): pc_write=0, if_id_write=0, ctl_bubble=1, flushes 0.
REQ-024 Load-use (no flush, no ext_stall): pc_write=0, if_id_write=0, ctl_bubble=1, flushes 0; exactly one stall cycle per load (ID/EX bubble clears memread next cycle).
REQ-025 Run: pc_write=1, if_id_write=1, ctl_bubble=0, flushes 0.
REQ-026 state register loads each cycle the condition that won REQ-021 priority (FLUSH, XSTALL, LDSTALL, RUN).
REQ-027 8-bit xstall_run counter increments each XSTALL-winning cycle, clears on any other cycle; on reaching 255 with ext_stall still winning, stall_timeout sets and holds until rst; counter saturates at 255.
REQ-028 stall_count +1 per LDSTALL or XSTALL-winning cycle; flush_count +1 per FLUSH cycle; both saturate at 16'hFFFF.

Reset
REQ-029 On clk edge with rst=1: state=00, xstall_run=0, stall_timeout=0, stall_count=0, flush_count=0.
REQ-030 While rst=1, control outputs forced to pc_write=0, if_id_write=0, ctl_bubble=1, if_id_flush=1, id_ex_flush=1; first cycle after rst deasserts follows REQ-021.
REQ-031 rst mid-stall or mid-flush abandons it; no pending event survives reset.

Configuration
REQ-032 Macro HAZARD_STATS_EN defined: stall_count/flush_count per REQ-028; undefined: counters not built, both ports constant 0, REQ-001..031 otherwise unchanged.

Verification
REQ-033 id_ex_memread=1, id_ex_rt=5, if_id_rs=5, opcode=000000 -> pc_write=0, if_id_write=0, ctl_bubble=1 one cycle; next edge state=01; memread=0 next cycle -> RUN outputs.
REQ-034 id_ex_rt=5, if_id_rt=5, opcode=100011 (lw), rs=3 -> no stall; id_ex_rt=0, rs=0 -> no stall.
REQ-035 ext_stall=1 and load_use=1 and ex_mem_branch_taken=1 same cycle -> flush outputs all 1, state=11, flush_count +1.
REQ-036 ext_stall held 256 cycles -> stall_timeout=1 after 256th XSTALL cycle, remains 1 after ext_stall=0 until rst.
REQ-037 With HAZARD_STATS_EN, 3 load-use stalls + 4 ext-stall cycles -> stall_count=7; without macro -> 0.
REQ-038 rst=1 during XSTALL -> next edge state=00, counters 0, stall_timeout=0; outputs per REQ-030 while asserted.

Source files
------------

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: flush / external-stall / load-use arbitration with stall watchdog.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  if_id_opcode,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rt,
  input  logic        ex_mem_branch_taken,
  input  logic        ext_stall,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        ctl_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  state,
  output logic        stall_timeout,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    XSTALL  = 2'b10,
    FLUSH   = 2'b11
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] xstall_run_reg;
  logic       stall_timeout_reg;
  logic       rt_src;
  logic       load_use;

  // rt is a source operand only for R-type, beq and sw.
  always_comb begin
    rt_src = (if_id_opcode == 6'b000000) ||
             (if_id_opcode == 6'b000100) ||
             (if_id_opcode == 6'b101011);
  end

  always_comb begin
    load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == if_id_rs) || (rt_src && (id_ex_rt == if_id_rt)));
  end

  always_comb begin
    state_next  = RUN;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    ctl_bubble  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (ex_mem_branch_taken) begin
      state_next  = FLUSH;
      ctl_bubble  = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ext_stall) begin
      state_next  = XSTALL;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctl_bubble  = 1'b1;
    end else if (load_use) begin
      state_next  = LDSTALL;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctl_bubble  = 1'b1;
    end
    // Hold the pipeline frozen and cleared while reset is asserted.
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctl_bubble  = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= RUN;
      xstall_run_reg    <= 8'd0;
      stall_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == XSTALL) begin
        // Counter parks at 255; one more winning cycle trips the sticky flag.
        if (xstall_run_reg == 8'hFF) begin
          stall_timeout_reg <= 1'b1;
        end else begin
          xstall_run_reg <= xstall_run_reg + 8'd1;
        end
      end else begin
        xstall_run_reg <= 8'd0;
      end
    end
  end

  assign state         = state_reg;
  assign stall_timeout = stall_timeout_reg;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count_reg;
  logic [15:0] flush_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= 16'd0;
      flush_count_reg <= 16'd0;
    end else begin
      if (((state_next == LDSTALL) || (state_next == XSTALL)) && (stall_count_reg != 16'hFFFF)) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
      if ((state_next == FLUSH) && (flush_count_reg != 16'hFFFF)) begin
        flush_count_reg <= flush_count_reg + 16'd1;
      end
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;
`else
  assign stall_count = 16'd0;
  assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed, table-driven bench for hazard_ctl plus watchdog, statistics and reset sequences.
module tb_hazard_ctl;

  logic        clk;
  logic        rst;
  logic [5:0]  if_id_opcode;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rt;
  logic        ex_mem_branch_taken;
  logic        ext_stall;
  logic        pc_write;
  logic        if_id_write;
  logic        ctl_bubble;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [1:0]  state;
  logic        stall_timeout;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  int checks = 0;
  int errors = 0;

  hazard_ctl dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_id_opcode        (if_id_opcode),
    .if_id_rs            (if_id_rs),
    .if_id_rt            (if_id_rt),
    .id_ex_memread       (id_ex_memread),
    .id_ex_rt            (id_ex_rt),
    .ex_mem_branch_taken (ex_mem_branch_taken),
    .ext_stall           (ext_stall),
    .pc_write            (pc_write),
    .if_id_write         (if_id_write),
    .ctl_bubble          (ctl_bubble),
    .if_id_flush         (if_id_flush),
    .id_ex_flush         (id_ex_flush),
    .state               (state),
    .stall_timeout       (stall_timeout),
    .stall_count         (stall_count),
    .flush_count         (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp_ctl = {pc_write, if_id_write, ctl_bubble, if_id_flush, id_ex_flush}
  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] xrt;
    logic       br;
    logic       xs;
    logic [4:0] exp_ctl;
    logic [1:0] exp_st;
  } vec_t;

  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00100;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_RST   = 5'b00111;

  vec_t vecs [15];

  function automatic logic [4:0] ctl_now();
    return {pc_write, if_id_write, ctl_bubble, if_id_flush, id_ex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] xrt, input logic br, input logic xs);
    @(negedge clk);
    if_id_opcode        = op;
    if_id_rs            = rs;
    if_id_rt            = rt;
    id_ex_memread       = mr;
    id_ex_rt            = xrt;
    ex_mem_branch_taken = br;
    ext_stall           = xs;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_stall;
  logic [15:0] exp_flush;

  initial begin
    vecs[0]  = '{6'b100011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN,   2'b00};
    vecs[1]  = '{6'b000000, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, C_STALL, 2'b01};
    vecs[2]  = '{6'b000000, 5'd5, 5'd7, 1'b0, 5'd5, 1'b0, 1'b0, C_RUN,   2'b00};
    vecs[3]  = '{6'b100011, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, C_RUN,   2'b00};
    vecs[4]  = '{6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, C_RUN,   2'b00};
    vecs[5]  = '{6'b000100, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, C_STALL, 2'b01};
    vecs[6]  = '{6'b101011, 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, C_STALL, 2'b01};
    vecs[7]  = '{6'b000000, 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, C_STALL, 2'b01};
    vecs[8]  = '{6'b001000, 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, C_RUN,   2'b00};
    vecs[9]  = '{6'b000000, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, C_RUN,   2'b00};
    vecs[10] = '{6'b100011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, C_STALL, 2'b10};
    vecs[11] = '{6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b1, C_STALL, 2'b10};
    vecs[12] = '{6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, C_FLUSH, 2'b11};
    vecs[13] = '{6'b100011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, C_FLUSH, 2'b11};
    vecs[14] = '{6'b100011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN,   2'b00};

    rst = 1'b1;
    if_id_opcode = 6'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    id_ex_memread = 1'b0; id_ex_rt = 5'd0; ex_mem_branch_taken = 1'b0; ext_stall = 1'b0;

    // Reset state and forced outputs, even with a branch request present
    drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("rst_ctl", {27'd0, ctl_now()}, {27'd0, C_RST});
    edge_wait();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_timeout", {31'd0, stall_timeout}, 32'd0);
    chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
    chk("rst_flush_count", {16'd0, flush_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: combinational controls then the registered winning state
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].xrt, vecs[i].br, vecs[i].xs);
      chk($sformatf("vec%0d_ctl", i), {27'd0, ctl_now()}, {27'd0, vecs[i].exp_ctl});
      edge_wait();
      chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].exp_st});
    end
`ifdef HAZARD_STATS_EN
    exp_stall = 16'd6;
    exp_flush = 16'd2;
`else
    exp_stall = 16'd0;
    exp_flush = 16'd0;
`endif
    chk("table_stall_count", {16'd0, stall_count}, {16'd0, exp_stall});
    chk("table_flush_count", {16'd0, flush_count}, {16'd0, exp_flush});

    // Statistics: 3 load-use stalls + 4 ext-stall cycles after a fresh reset
    @(negedge clk); rst = 1'b1;
    edge_wait();
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(6'b000000, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
      edge_wait();
      drive(6'b000000, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
      edge_wait();
    end
    for (int k = 0; k < 4; k++) begin
      drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      edge_wait();
    end
    drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    edge_wait();
`ifdef HAZARD_STATS_EN
    exp_stall = 16'd7;
`else
    exp_stall = 16'd0;
`endif
    chk("stats_stall_count", {16'd0, stall_count}, {16'd0, exp_stall});
    chk("stats_flush_count", {16'd0, flush_count}, 32'd0);

    // Watchdog: 255 XSTALL cycles leave the flag clear, the 256th sets it
    drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int k = 0; k < 255; k++) edge_wait();
    chk("wd_255_timeout", {31'd0, stall_timeout}, 32'd0);
    chk("wd_255_state", {30'd0, state}, 32'd2);
    edge_wait();
    chk("wd_256_timeout", {31'd0, stall_timeout}, 32'd1);
    drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("wd_release_ctl", {27'd0, ctl_now()}, {27'd0, C_RUN});
    for (int k = 0; k < 3; k++) edge_wait();
    chk("wd_sticky_timeout", {31'd0, stall_timeout}, 32'd1);
    chk("wd_release_state", {30'd0, state}, 32'd0);

    // Reset in the middle of an external stall
    drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    edge_wait();
    chk("mid_xstall_state", {30'd0, state}, 32'd2);
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rst_ctl", {27'd0, ctl_now()}, {27'd0, C_RST});
    edge_wait();
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_timeout", {31'd0, stall_timeout}, 32'd0);
    chk("mid_rst_stall_count", {16'd0, stall_count}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_ctl", {27'd0, ctl_now()}, {27'd0, C_STALL});
    edge_wait();
    chk("post_rst_state", {30'd0, state}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
